// File: rtl/bch_tables.sv
// Shared definitions for the BCH(15,7) t=2 Chien search over GF(16).
// Holds the field width, the x^4+x+1 feedback taps, the alpha power table
// and the search FSM state type.
package bch_tables;

  localparam int GF_M = 4;
  localparam int GF_N = 15;

  // Feedback taps of x^4+x+1 applied when the MSB shifts out.
  localparam logic [GF_M-1:0] GF_POLY = 4'b0011;

  // alpha^k for k = 0..14 in polynomial basis.
  localparam logic [GF_M-1:0] ALPHA_POW [0:GF_N-1] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/bch_chien_search_gf_mul_alpha.sv
// gf_mul_alpha: constant multiply by alpha in GF(16), pure XOR network.
// Ports: a - field element in, y - a*alpha out.
// Combinational, zero latency, no flow control.
import bch_tables::*;

module gf_mul_alpha (
  input  logic [GF_M-1:0] a,
  output logic [GF_M-1:0] y
);

  assign y = {a[GF_M-2:0], 1'b0} ^ (a[GF_M-1] ? GF_POLY : '0);

endmodule

// File: rtl/bch_chien_search.sv
// bch_chien_search: serial Chien search of L(x)=1+l1*x+l2*x^2 over GF(16),
// strobing err_bit for positions 14..0 and reporting err_vec/err_count/dec_fail.
// Ports: clk, rst (sync active-low); in_valid/in_ready/lambda1/lambda2 input
// handshake; err_bit_valid/err_bit/err_pos per-cycle strobe; out_valid/out_ready
// result handshake with err_vec, err_count, dec_fail.
// Latency: accept at cycle 0, strobes cycles 1..15, result from cycle 16; one
// job in flight, so in_ready stays low until the result is taken.
import bch_tables::*;

module bch_chien_search #(
  parameter int N = 15,
  parameter int M = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  lambda1,
  input  logic [M-1:0]  lambda2,
  output logic          err_bit_valid,
  output logic          err_bit,
  output logic [3:0]    err_pos,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  err_vec,
  output logic [1:0]    err_count,
  output logic          dec_fail
);

  state_t         state_q, state_d;
  logic [M-1:0]   r1_q, r2_q;
  logic [3:0]     k_q;
  logic [N-1:0]   vec_q;
  logic [1:0]     cnt_q;
  logic [1:0]     deg_q;

  logic [M-1:0]   mul_in1, mul_in2;
  logic [M-1:0]   r1_nx, r2_mid, r2_nx;
  logic [M-1:0]   s;
  logic           hit;
  logic [3:0]     pos;

  // In IDLE the multipliers see the incoming lambdas so the same instances
  // produce the first-step terms l1*alpha and l2*alpha^2 on load.
  assign mul_in1 = (state_q == IDLE) ? lambda1 : r1_q;
  assign mul_in2 = (state_q == IDLE) ? lambda2 : r2_q;

  gf_mul_alpha u_mul_r1  (.a(mul_in1), .y(r1_nx));
  gf_mul_alpha u_mul_r2a (.a(mul_in2), .y(r2_mid));
  gf_mul_alpha u_mul_r2b (.a(r2_mid),  .y(r2_nx));

  assign s   = 4'b0001 ^ r1_q ^ r2_q;
  assign hit = (state_q == SEARCH) && (s == '0);
  // Evaluating at alpha^k locates an error at codeword position 15-k.
  assign pos = 4'd15 - k_q;

  always_comb begin
    state_d       = state_q;
    in_ready      = 1'b0;
    err_bit_valid = 1'b0;
    err_bit       = 1'b0;
    err_pos       = '0;
    out_valid     = 1'b0;
    err_vec       = '0;
    err_count     = '0;
    dec_fail      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SEARCH;
      end
      SEARCH: begin
        err_bit_valid = 1'b1;
        err_pos       = pos;
        err_bit       = hit;
        if (k_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        err_vec   = vec_q;
        err_count = (cnt_q == 2'd3) ? 2'd2 : cnt_q;
        // A degree-d locator must have exactly d distinct roots in the field.
        dec_fail  = (cnt_q != deg_q) || (cnt_q == 2'd3);
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
      k_q     <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      deg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        r1_q  <= r1_nx;
        r2_q  <= r2_nx;
        k_q   <= 4'd1;
        vec_q <= '0;
        cnt_q <= '0;
        deg_q <= (lambda2 != '0) ? 2'd2 : ((lambda1 != '0) ? 2'd1 : 2'd0);
      end else if (state_q == SEARCH) begin
        r1_q <= r1_nx;
        r2_q <= r2_nx;
        k_q  <= k_q + 4'd1;
        if (hit) begin
          vec_q[pos] <= 1'b1;
          if (cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bch_chien_search.sv
module tb_bch_chien_search;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  lambda1, lambda2;
  logic        err_bit_valid, err_bit;
  logic [3:0]  err_pos;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] err_vec;
  logic [1:0]  err_count;
  logic        dec_fail;

  int checks = 0;
  int errors = 0;

  // per-search observations
  logic        obs_ebv [15];
  logic [3:0]  obs_pos [15];
  logic        obs_bit [15];
  logic        obs_rdy [15];
  logic [14:0] obs_hits;

  // reference results
  logic [14:0] exp_vec;
  logic [1:0]  exp_cnt;
  logic        exp_fail;
  logic        exp_hit [15];

  bch_chien_search dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lambda1(lambda1), .lambda2(lambda2), .err_bit_valid(err_bit_valid),
    .err_bit(err_bit), .err_pos(err_pos), .out_valid(out_valid),
    .out_ready(out_ready), .err_vec(err_vec), .err_count(err_count),
    .dec_fail(dec_fail)
  );

  always #5 clk = ~clk;

  // Generic GF(16) product: carry-less multiply then reduce by x^4+x+1.
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
    for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (7'b0010011 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] apow(input int k);
    logic [3:0] x;
    x = 4'h1;
    for (int i = 0; i < k; i++) x = gmul(x, 4'h2);
    return x;
  endfunction

  // Evaluate the locator at every nonzero field element directly.
  task automatic model(input logic [3:0] l1, input logic [3:0] l2);
    int cnt, deg;
    logic [3:0] x;
    exp_vec = '0;
    cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      x = apow(k);
      exp_hit[k-1] = ((4'h1 ^ gmul(l1, x) ^ gmul(l2, gmul(x, x))) == 4'h0);
      if (exp_hit[k-1]) begin
        exp_vec[15-k] = 1'b1;
        cnt++;
      end
    end
    deg = (l2 != 0) ? 2 : ((l1 != 0) ? 1 : 0);
    exp_cnt  = (cnt > 2) ? 2'd2 : 2'(cnt);
    exp_fail = (cnt != deg);
  endtask

  // Offer one lambda pair and step through the 15 search cycles, recording
  // what the DUT shows; ends at the negedge of the first DONE cycle.
  task automatic run_search(input logic [3:0] l1, input logic [3:0] l2, input bit noise);
    in_valid = 1'b1;
    lambda1  = l1;
    lambda2  = l2;
    obs_hits = '0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      obs_ebv[i] = err_bit_valid;
      obs_pos[i] = err_pos;
      obs_bit[i] = err_bit;
      obs_rdy[i] = in_ready;
      if (err_bit) obs_hits[err_pos] = 1'b1;
      if (noise) begin
        in_valid  = 1'b1;
        lambda1   = 4'($urandom_range(0, 15));
        lambda2   = 4'($urandom_range(0, 15));
        out_ready = (i < 14);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; lambda1 = '0; lambda2 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || err_bit_valid !== 1'b0 ||
        err_bit !== 1'b0 || err_pos !== 4'd0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b ebv=%b eb=%b pos=%0d, required 1 0 0 0 0",
               in_ready, out_valid, err_bit_valid, err_bit, err_pos);
    end
    checks++;
    if (err_vec !== 15'h0 || err_count !== 2'd0 || dec_fail !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: vec=%h cnt=%0d fail=%b, required 0 0 0", err_vec, err_count, dec_fail);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_error();
    run_search(4'b1000, 4'b0000, 1'b0);
    checks++;
    if (obs_hits !== 15'h0008 || obs_bit[11] !== 1'b1) begin
      errors++;
      $display("FAIL single_strobes: hits=%h bit@k12=%b, required 0008 1", obs_hits, obs_bit[11]);
    end
    checks++;
    if (out_valid !== 1'b1 || err_vec !== 15'h0008 || err_count !== 2'd1 || dec_fail !== 1'b0) begin
      errors++;
      $display("FAIL single_result: ov=%b vec=%h cnt=%0d fail=%b, required 1 0008 1 0",
               out_valid, err_vec, err_count, dec_fail);
    end
    release_result();
  endtask

  task automatic test_double_error();
    run_search(4'b0111, 4'b0110, 1'b0);
    checks++;
    if (obs_hits !== 15'h0021) begin
      errors++;
      $display("FAIL double_strobes: hits=%h, required 0021", obs_hits);
    end
    checks++;
    if (out_valid !== 1'b1 || err_vec !== 15'h0021 || err_count !== 2'd2 || dec_fail !== 1'b0) begin
      errors++;
      $display("FAIL double_result: ov=%b vec=%h cnt=%0d fail=%b, required 1 0021 2 0",
               out_valid, err_vec, err_count, dec_fail);
    end
    release_result();
  endtask

  task automatic test_zero_locator();
    int nstrobe;
    run_search(4'b0000, 4'b0000, 1'b0);
    nstrobe = 0;
    for (int i = 0; i < 15; i++) if (obs_ebv[i] === 1'b1 && obs_bit[i] === 1'b0) nstrobe++;
    checks++;
    if (nstrobe != 15) begin
      errors++;
      $display("FAIL zero_strobes: clean strobes=%0d, required 15", nstrobe);
    end
    checks++;
    if (out_valid !== 1'b1 || err_vec !== 15'h0 || err_count !== 2'd0 || dec_fail !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: ov=%b vec=%h cnt=%0d fail=%b, required 1 0000 0 0",
               out_valid, err_vec, err_count, dec_fail);
    end
    release_result();
  endtask

  task automatic test_repeated_root();
    run_search(4'b0000, 4'b0001, 1'b0);
    checks++;
    if (obs_hits !== 15'h0001) begin
      errors++;
      $display("FAIL repeat_strobes: hits=%h, required 0001", obs_hits);
    end
    checks++;
    if (out_valid !== 1'b1 || err_vec !== 15'h0001 || err_count !== 2'd1 || dec_fail !== 1'b1) begin
      errors++;
      $display("FAIL repeat_result: ov=%b vec=%h cnt=%0d fail=%b, required 1 0001 1 1",
               out_valid, err_vec, err_count, dec_fail);
    end
    release_result();
  endtask

  task automatic test_handshake();
    // in_valid and out_ready toggle during the search and must be ignored.
    model(4'b0111, 4'b0110);
    run_search(4'b0111, 4'b0110, 1'b1);
    checks++;
    if (obs_hits !== exp_vec) begin
      errors++;
      $display("FAIL hs_noise_strobes: hits=%h, required %h", obs_hits, exp_vec);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || err_vec !== exp_vec ||
          err_count !== exp_cnt || dec_fail !== exp_fail) begin
        errors++;
        $display("FAIL hs_hold%0d: ov=%b rdy=%b vec=%h cnt=%0d fail=%b, required 1 0 %h %0d %b",
                 c, out_valid, in_ready, err_vec, err_count, dec_fail, exp_vec, exp_cnt, exp_fail);
      end
      @(negedge clk);
    end
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_release: rdy=%b ov=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_search();
    in_valid = 1'b1; lambda1 = 4'b1000; lambda2 = 4'b0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (err_bit_valid !== 1'b1 || err_pos !== 4'd8) begin
      errors++;
      $display("FAIL midrst_k7: ebv=%b pos=%0d, required 1 8", err_bit_valid, err_pos);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || err_bit_valid !== 1'b0 || err_bit !== 1'b0 || err_pos !== 4'd0 ||
        out_valid !== 1'b0 || err_vec !== 15'h0 || err_count !== 2'd0 || dec_fail !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: rdy=%b ebv=%b eb=%b pos=%0d ov=%b vec=%h cnt=%0d fail=%b, required 1 0 0 0 0 0 0 0",
               in_ready, err_bit_valid, err_bit, err_pos, out_valid, err_vec, err_count, dec_fail);
    end
    run_search(4'b0111, 4'b0110, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || err_vec !== 15'h0021 || err_count !== 2'd2 || dec_fail !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next: ov=%b vec=%h cnt=%0d fail=%b, required 1 0021 2 0",
               out_valid, err_vec, err_count, dec_fail);
    end
    release_result();
  endtask

  task automatic test_random();
    logic [3:0] l1, l2;
    for (int j = 0; j < 30; j++) begin
      l1 = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      l2 = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      model(l1, l2);
      run_search(l1, l2, j[0]);
      for (int i = 0; i < 15; i++) begin
        checks++;
        if (obs_ebv[i] !== 1'b1 || obs_rdy[i] !== 1'b0 || obs_pos[i] !== 4'(14 - i) ||
            obs_bit[i] !== exp_hit[i]) begin
          errors++;
          $display("FAIL rand%0d_k%0d: ebv=%b rdy=%b pos=%0d bit=%b, required 1 0 %0d %b (l1=%h l2=%h)",
                   j, i + 1, obs_ebv[i], obs_rdy[i], obs_pos[i], obs_bit[i], 14 - i, exp_hit[i], l1, l2);
        end
      end
      checks++;
      if (out_valid !== 1'b1 || err_vec !== exp_vec || err_count !== exp_cnt || dec_fail !== exp_fail) begin
        errors++;
        $display("FAIL rand%0d_result: ov=%b vec=%h cnt=%0d fail=%b, required 1 %h %0d %b (l1=%h l2=%h)",
                 j, out_valid, err_vec, err_count, dec_fail, exp_vec, exp_cnt, exp_fail, l1, l2);
      end
      release_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_release: rdy=%b ov=%b, required 1 0", j, in_ready, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_error();
    test_double_error();
    test_zero_locator();
    test_repeated_root();
    test_handshake();
    test_reset_mid_search();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bch_chien_search.md
Name: bch_chien_search

Overview:
- Downstream stage of the BCH(15,7) t=2 error-locator block. Accepts lambda1 and lambda2 of Λ(x)=1+λ1·x+λ2·x² over GF(16), primitive polynomial x⁴+x+1.
- Serially evaluates Λ(α^k) for k=1..15 and reports a per-cycle error strobe for codeword positions 14 down to 0.
- Produces a final 15-bit error vector and a decode-failure flag for the correction stage.

Parameters:
- N, 15, codeword length; only 15 is supported.
- M, 4, GF symbol width; only 4 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  lambda pair valid.
- in_ready  out  1  block can accept a lambda pair.
- lambda1  in  4  Λ coefficient of x.
- lambda2  in  4  Λ coefficient of x².
- err_bit_valid  out  1  high on each search cycle.
- err_bit  out  1  current position is in error.
- err_pos  out  4  current position (14..0).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- err_vec  out  15  bit j set means codeword bit j is in error.
- err_count  out  2  number of roots found (0..2, saturating).
- dec_fail  out  1  root count differs from deg Λ.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE.
  - in_ready=1; all other outputs 0; err_vec=0, err_count=0, dec_fail=0.
  - Internal registers cleared.
  - Applies immediately, including mid-SEARCH or mid-DONE; no partial result is emitted.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - r1 ← λ1·α and r2 ← λ2·α².
    - Latch deg: 2 if λ2≠0, else 1 if λ1≠0, else 0.
    - Clear err_vec and the root count; k ← 1; go to SEARCH.
- SEARCH (exactly 15 cycles, k=1..15):
  - Combinational sum s = 1 ⊕ r1 ⊕ r2.
  - err_bit_valid=1, err_pos=15−k, err_bit=(s==0).
  - At the clk edge:
    - If s==0: err_vec[15−k] ← 1 and the root count increments, saturating at 3 internally.
    - r1 ← r1·α, r2 ← r2·α² (constant GF multipliers, XOR networks only).
    - k ← k+1.
  - After k=15 (position 0), go to DONE.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1. Outputs hold stable: err_vec; err_count = min(count,2); dec_fail = (count≠deg) or (count>2).
  - On out_ready, return to IDLE.
  - in_ready=0 in DONE, so no overlap with the next job.
- Latency:
  - Acceptance at cycle 0.
  - err_bit strobes in cycles 1..15.
  - out_valid from cycle 16 onward.
  - Minimum throughput is 17 cycles per codeword.
- Boundary conditions:
  - λ1=λ2=0: no roots, deg 0, err_vec=0, dec_fail=0.
  - A repeated root (e.g. λ1=0, λ2≠0) is counted once, giving dec_fail=1.
  - in_valid during SEARCH or DONE is ignored; the upstream holds it until in_ready.
  - out_ready while not in DONE has no effect.
  - k wraps only by exit to DONE; k=15 corresponds to α^15=α^0.
- Arithmetic:
  - All field additions are 4-bit XOR.
  - ·α: shift left, XOR 0011 if the MSB was set.
  - ·α² is two ·α steps.

Decomposition:
- Shared package in bch_tables.sv:
  - GF width constant.
  - Primitive polynomial constant 4'b0011 (feedback taps).
  - α^k lookup table.
  - State enum type.
- One sub-module, gf_mul_alpha, is natural: combinational constant multiply by α. Instantiate three times: one for r1, two chained for r2. The load path reuses the same instances.

Test Plan:
- Single error: λ1=4'b1000 (α³), λ2=0.
  - Required: err_bit only at err_pos=3, i.e. cycle 12.
  - Required: err_vec=15'h0008, err_count=1, dec_fail=0.
- Double error: λ1=4'b0111 (α¹⁰), λ2=4'b0110 (α⁵).
  - Required: err_bit at err_pos 5 and 0.
  - Required: err_vec=15'h0021, err_count=2, dec_fail=0.
- Zero locator: λ1=0, λ2=0.
  - Required: 15 strobes with err_bit=0.
  - Required: err_vec=0, err_count=0, dec_fail=0.
- Repeated root: λ1=0, λ2=4'b0001.
  - Required: single hit at pos 0.
  - Required: err_vec=15'h0001, err_count=1, dec_fail=1.
- Handshake:
  - Hold out_ready=0 for 5 cycles after DONE. Required: outputs stable, in_ready=0.
  - Assert in_valid during SEARCH. Required: ignored.
  - Assert out_ready. Required: in_ready=1 on the next cycle.
- Reset mid-SEARCH: drive rst=0 at k=7.
  - Required: next cycle IDLE, all outputs 0, in_ready=1.
  - Required: a following job produces a correct result.
